// File: rtl/pc_gen.sv
// pc_gen: fetch-stage program-counter generator.
// Holds the fetch PC, qualifies it with pc_valid_o while running, and picks the
// next PC from flush / jump / branch / sequential increment in fixed priority.
// Keeps a saturating count of accepted redirects for performance debug.
// Optional build macro PC_ALIGN_CHK_EN: reject misaligned jump/branch targets
// (halt and raise the sticky misalign_o flag). Undefined by default.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | after reset; PC not valid, waits for start_i (flush still loads PC)
// RUN   | fetching; PC advances or redirects every unstalled cycle
// HALT  | fetching stopped; PC held until start_i or flush_i
// BAD   | unused encoding 11; recovers to IDLE on the next cycle

module pc_gen #(
  parameter int                ADDR_W     = 32,
  parameter logic [ADDR_W-1:0] RESET_VEC  = '0,
  parameter int                INST_BYTES = 4,
  parameter int                CNT_W      = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic              stall_i,
  input  logic              halt_i,
  input  logic              flush_i,
  input  logic [ADDR_W-1:0] flush_pc_i,
  input  logic              jump_i,
  input  logic [ADDR_W-1:0] jump_pc_i,
  input  logic              br_taken_i,
  input  logic [ADDR_W-1:0] br_pc_i,
  output logic [ADDR_W-1:0] pc_o,
  output logic              pc_valid_o,
  output logic [1:0]        state_o,
  output logic [CNT_W-1:0]  redir_cnt_o,
  output logic              misalign_o
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_HALT = 2'b10,
    ST_BAD  = 2'b11
  } state_t;

  localparam logic [ADDR_W-1:0] PC_INC = ADDR_W'(INST_BYTES);

  state_t             state_q, state_d;
  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic [CNT_W-1:0]   cnt_q;
  logic               cnt_inc;

`ifdef PC_ALIGN_CHK_EN
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ADDR_W'(INST_BYTES - 1);

  logic mis_q;
  logic mis_set;
  logic mis_clr;
  logic jump_bad;
  logic br_bad;

  // A target is misaligned when any of its sub-instruction byte bits is set.
  always_comb begin
    jump_bad = (jump_pc_i & ALIGN_MASK) != '0;
    br_bad   = (br_pc_i & ALIGN_MASK) != '0;
  end
`endif

  // Next-state / next-PC selection with fixed redirect priority.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cnt_inc = 1'b0;
`ifdef PC_ALIGN_CHK_EN
    mis_set = 1'b0;
    mis_clr = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (flush_i) begin
          pc_d    = flush_pc_i;
          cnt_inc = 1'b1;
`ifdef PC_ALIGN_CHK_EN
          mis_clr = 1'b1;
`endif
        end else if (start_i) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (flush_i) begin
          pc_d    = flush_pc_i;
          cnt_inc = 1'b1;
`ifdef PC_ALIGN_CHK_EN
          mis_clr = 1'b1;
`endif
        end else if (stall_i) begin
          // hold; any jump/branch this cycle is dropped
        end else if (halt_i) begin
          state_d = ST_HALT;
        end else if (jump_i) begin
`ifdef PC_ALIGN_CHK_EN
          if (jump_bad) begin
            state_d = ST_HALT;
            mis_set = 1'b1;
          end else begin
            pc_d    = jump_pc_i;
            cnt_inc = 1'b1;
          end
`else
          pc_d    = jump_pc_i;
          cnt_inc = 1'b1;
`endif
        end else if (br_taken_i) begin
`ifdef PC_ALIGN_CHK_EN
          if (br_bad) begin
            state_d = ST_HALT;
            mis_set = 1'b1;
          end else begin
            pc_d    = br_pc_i;
            cnt_inc = 1'b1;
          end
`else
          pc_d    = br_pc_i;
          cnt_inc = 1'b1;
`endif
        end else begin
          pc_d = pc_q + PC_INC;
        end
      end
      ST_HALT: begin
        if (flush_i) begin
          pc_d    = flush_pc_i;
          state_d = ST_RUN;
          cnt_inc = 1'b1;
`ifdef PC_ALIGN_CHK_EN
          mis_clr = 1'b1;
`endif
        end else if (start_i) begin
          state_d = ST_RUN;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and PC registers, synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q <= ST_IDLE;
      pc_q    <= RESET_VEC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  // Redirect counter sticks at all-ones instead of wrapping.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      cnt_q <= '0;
    end else if (cnt_inc && (cnt_q != '1)) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

`ifdef PC_ALIGN_CHK_EN
  // Sticky misalign flag; set and clear never coincide (different branches).
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      mis_q <= 1'b0;
    end else if (mis_clr) begin
      mis_q <= 1'b0;
    end else if (mis_set) begin
      mis_q <= 1'b1;
    end
  end

  assign misalign_o = mis_q;
`else
  assign misalign_o = 1'b0;
`endif

  assign pc_o        = pc_q;
  assign pc_valid_o  = (state_q == ST_RUN);
  assign state_o     = state_q;
  assign redir_cnt_o = cnt_q;

endmodule
